// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// next-PC select encodings and the reset/bubble instruction.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_EXEC = 2'b10,
      ST_HALT = 2'b11
   } fetch_state_t;

   // Next-PC select, sampled with retire. The unused code 2'b11 falls back to PC+4.
   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JALR   = 2'b10;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // True when an address is not on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential (+4), branch/JAL (+imm)
// or JALR (ALU result with bit 0 cleared), plus the alignment flag.
module next_pc_calc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [1:0]  i_pc_src,
   input  logic [31:0] i_imm_ext,
   input  logic [31:0] i_alu_result,
   output logic [31:0] o_pc_plus4,
   output logic [31:0] o_next_pc,
   output logic        o_misaligned
);

   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_branch;
   logic [31:0] w_pc_jalr;
   logic [31:0] w_next_pc;

   // Candidate targets; all adders wrap modulo 2^32.
   always_comb begin
      w_pc_plus4  = i_pc + 32'd4;
      w_pc_branch = i_pc + i_imm_ext;
      w_pc_jalr   = i_alu_result & ~32'd1;
   end

   // Target select; unused encoding behaves as sequential fetch.
   always_comb begin
      w_next_pc = w_pc_plus4;
      case (i_pc_src)
         PCSRC_BRANCH: w_next_pc = w_pc_branch;
         PCSRC_JALR:   w_next_pc = w_pc_jalr;
         default:      w_next_pc = w_pc_plus4;
      endcase
   end

   assign o_pc_plus4   = w_pc_plus4;
   assign o_next_pc    = w_next_pc;
   assign o_misaligned = is_misaligned(w_next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time
// over a req/ready handshake, holds it until execute retires it, then
// steps to the selected next PC or halts on a misaligned target.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic [1:0]  pc_src,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   output logic        misaligned
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic         r_instr_valid;
   logic         r_imem_req;
   logic         r_misaligned;

   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_next_pc;
   logic         w_next_misaligned;

   next_pc_calc u_next_pc (
      .i_pc         (r_pc),
      .i_pc_src     (pc_src),
      .i_imm_ext    (imm_ext),
      .i_alu_result (alu_result),
      .o_pc_plus4   (w_pc_plus4),
      .o_next_pc    (w_next_pc),
      .o_misaligned (w_next_misaligned)
   );

   // Fetch FSM: request, hold for execute, advance PC on retire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_misaligned  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_imem_req <= 1'b1;
               r_state    <= ST_REQ;
            end
            ST_REQ: begin
               if (imem_ready) begin
                  r_instr       <= imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (retire) begin
                  r_instr_valid <= 1'b0;
                  if (w_next_misaligned) begin
                     r_misaligned <= 1'b1;
                     r_state      <= ST_HALT;
                  end else begin
                     r_pc       <= w_next_pc;
                     r_imem_req <= 1'b1;
                     r_state    <= ST_REQ;
                  end
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic [1:0]  pc_src;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        misaligned;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .retire     (retire),
      .pc_src     (pc_src),
      .imm_ext    (imm_ext),
      .alu_result (alu_result),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int unsigned n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check_eq("req_wait", {31'b0, imem_req}, 32'd1);
   endtask

   // Serve one zero-wait fetch at exp_addr and check the held instruction.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
      wait_req();
      check_eq("req_addr", imem_addr, exp_addr);
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imem_ready = 1'b0;
      check_eq("valid_after_ready", {31'b0, instr_valid}, 32'd1);
      check_eq("instr_held", instr, word);
      check_eq("req_drop", {31'b0, imem_req}, 32'd0);
      check_eq("pc_held", pc, exp_addr);
   endtask

   // Retire the held instruction and check the next request address.
   task automatic do_retire(input logic [1:0] src, input logic [31:0] imm,
                            input logic [31:0] alu, input logic [31:0] exp_next);
      pc_src     = src;
      imm_ext    = imm;
      alu_result = alu;
      retire     = 1'b1;
      step();
      retire = 1'b0;
      check_eq("ret_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("ret_req", {31'b0, imem_req}, 32'd1);
      check_eq("ret_addr", imem_addr, exp_next);
      check_eq("ret_pc", pc, exp_next);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      retire     = 1'b0;
      pc_src     = 2'b00;
      imm_ext    = 32'h0;
      alu_result = 32'h0;

      // Reset values
      #12;
      check_eq("rst_req", {31'b0, imem_req}, 32'd0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_instr", instr, 32'h0000_0013);
      check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_pc4", pc_plus4, 32'h4);
      check_eq("rst_mis", {31'b0, misaligned}, 32'd0);

      // First request in the second cycle after reset release
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("idle_no_req", {31'b0, imem_req}, 32'd0);
      step();
      check_eq("first_req", {31'b0, imem_req}, 32'd1);

      // Sequential fetch 0x0, 0x4, 0x8
      for (int k = 0; k < 3; k++) begin
         fetch(32'(4 * k), 32'h0000_1000 + 32'(k));
         check_eq("seq_pc4", pc_plus4, 32'(4 * k + 4));
         do_retire(2'b00, 32'h0, 32'h0, 32'(4 * k + 4));
      end

      // Branch targets
      fetch(32'h0000_000C, 32'h0000_0063);
      do_retire(2'b01, 32'h0000_00F4, 32'h0, 32'h0000_0100);
      fetch(32'h0000_0100, 32'h0000_0063);
      do_retire(2'b01, 32'hFFFF_FFF0, 32'h0, 32'h0000_00F0);
      fetch(32'h0000_00F0, 32'h0000_0063);
      do_retire(2'b01, 32'h0000_0010, 32'h0, 32'h0000_0100);
      fetch(32'h0000_0100, 32'h0000_006F);
      do_retire(2'b01, 32'h0000_0800, 32'h0, 32'h0000_0900);

      // JALR clears bit 0; code 11 behaves as +4
      fetch(32'h0000_0900, 32'h0000_0067);
      do_retire(2'b10, 32'h0, 32'h0000_2001, 32'h0000_2000);
      fetch(32'h0000_2000, 32'h0000_0013);
      do_retire(2'b11, 32'h0000_0040, 32'h0000_0100, 32'h0000_2004);

      // Three wait cycles; retire during REQ must be ignored
      for (int i = 0; i < 3; i++) begin
         retire = (i == 1);
         step();
         retire = 1'b0;
         check_eq("wait_req", {31'b0, imem_req}, 32'd1);
         check_eq("wait_addr", imem_addr, 32'h0000_2004);
         check_eq("wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      fetch(32'h0000_2004, 32'hCAFE_0013);

      // Ready during EXEC must be ignored
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ready = 1'b0;
      check_eq("exec_ready_instr", instr, 32'hCAFE_0013);
      check_eq("exec_ready_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("exec_ready_req", {31'b0, imem_req}, 32'd0);

      // PC wrap from 0xFFFF_FFFC
      do_retire(2'b10, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0000_0013);
      check_eq("wrap_pc4", pc_plus4, 32'h0);
      do_retire(2'b00, 32'h0, 32'h0, 32'h0);

      // Misaligned JALR target halts fetch
      fetch(32'h0, 32'h0000_0067);
      pc_src     = 2'b10;
      alu_result = 32'h0000_2002;
      retire     = 1'b1;
      step();
      retire = 1'b0;
      check_eq("mis_flag", {31'b0, misaligned}, 32'd1);
      check_eq("mis_req", {31'b0, imem_req}, 32'd0);
      check_eq("mis_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("mis_pc", pc, 32'h0);
      for (int i = 0; i < 3; i++) begin
         imem_ready = 1'b1;
         retire     = 1'b1;
         pc_src     = 2'b00;
         step();
         check_eq("halt_req", {31'b0, imem_req}, 32'd0);
         check_eq("halt_pc", pc, 32'h0);
         check_eq("halt_mis", {31'b0, misaligned}, 32'd1);
      end
      imem_ready = 1'b0;
      retire     = 1'b0;

      // Reset out of HALT
      reset = 1'b1;
      #1;
      check_eq("halt_rst_mis", {31'b0, misaligned}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      fetch(32'h0, 32'h0000_0013);
      do_retire(2'b00, 32'h0, 32'h0, 32'h4);

      // Reset mid-REQ with a late response
      reset = 1'b1;
      #1;
      check_eq("rreq_req", {31'b0, imem_req}, 32'd0);
      check_eq("rreq_pc", pc, 32'h0);
      check_eq("rreq_addr", imem_addr, 32'h0);
      imem_ready = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      reset = 1'b0;
      step();
      imem_ready = 1'b0;
      check_eq("late_instr", instr, 32'h0000_0013);
      check_eq("late_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("late_req", {31'b0, imem_req}, 32'd1);

      // Reset mid-EXEC
      fetch(32'h0, 32'hABCD_0013);
      reset = 1'b1;
      #1;
      check_eq("rexec_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("rexec_instr", instr, 32'h0000_0013);
      check_eq("rexec_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();
      wait_req();
      check_eq("resume_addr", imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
